// File: rtl/output_buffer_interface_if.sv
// -----------------------------------------------------------------------------
// output_buffer_interface_if
//   Bundles the bufid handshake, the PCB read port and the output packet
//   stream of output_buffer_interface into one interface.
//
//   Handshakes:
//     bufid in   : i_pkt_bufid_wr is a 1-cycle strobe. It is only legal while
//                  o_bufid_ready=1, and iv_pkt_bufid is valid with it.
//     PCB read   : o_pkt_rd/ov_pkt_bufadd are raised together and held stable
//                  until i_pkt_ack=1. iv_pkt_rdata is valid in the ack cycle.
//                  An ack while o_pkt_rd=0 has no effect.
//     packet out : ov_pkt is valid for exactly the cycle o_pkt_wr=1. New reads
//                  are not started while i_fifo_afull=1.
//     release    : o_bufid_release is a 1-cycle strobe. ov_bufid_release is
//                  valid with it.
//
//   Modports:
//     slave  - the output_buffer_interface block
//     master - the environment (scheduler, PCB, downstream FIFO)
// -----------------------------------------------------------------------------
interface output_buffer_interface_if;
    logic         i_pkt_bufid_wr;
    logic [8:0]   iv_pkt_bufid;
    logic         o_bufid_ready;
    logic         o_pkt_rd;
    logic [15:0]  ov_pkt_bufadd;
    logic         i_pkt_ack;
    logic [133:0] iv_pkt_rdata;
    logic         i_fifo_afull;
    logic [133:0] ov_pkt;
    logic         o_pkt_wr;
    logic         o_bufid_release;
    logic [8:0]   ov_bufid_release;
    logic         o_pkt_err;

    modport slave (
        input  i_pkt_bufid_wr, iv_pkt_bufid, i_pkt_ack, iv_pkt_rdata, i_fifo_afull,
        output o_bufid_ready, o_pkt_rd, ov_pkt_bufadd, ov_pkt, o_pkt_wr,
               o_bufid_release, ov_bufid_release, o_pkt_err
    );

    modport master (
        output i_pkt_bufid_wr, iv_pkt_bufid, i_pkt_ack, iv_pkt_rdata, i_fifo_afull,
        input  o_bufid_ready, o_pkt_rd, ov_pkt_bufadd, ov_pkt, o_pkt_wr,
               o_bufid_release, ov_bufid_release, o_pkt_err
    );
endinterface

// File: rtl/output_buffer_interface.sv
// -----------------------------------------------------------------------------
// output_buffer_interface
//   This block takes a packet bufid from the scheduler. It reads the packet
//   out of the packet centralized buffer one 134-bit word per request/ack
//   exchange and forwards each word downstream. After the packet's last word
//   it returns the bufid for release.
//   The word address is {bufid[8:0], offset[6:0]}, so each buffer holds 128
//   words. Word type is in [133:132]:
//     01 = head, 00 = body, 10 = tail, 11 = single-word
//
// Ports:
//   i_clk                       clock
//   i_rst_n                     asynchronous active-low reset
//   bus (slave modport)         bufid in, PCB read port, packet out, release
//   output_buf_interface_state  FSM state for debug
//                               00 idle, 01 rd_req, 10 wait_ack, 11 release
// -----------------------------------------------------------------------------
module output_buffer_interface (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    output_buffer_interface_if.slave   bus,
    output logic [1:0]                 output_buf_interface_state
);

    typedef enum logic [1:0] {
        IDLE_S     = 2'b00,
        RD_REQ_S   = 2'b01,
        WAIT_ACK_S = 2'b10,
        RELEASE_S  = 2'b11
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [8:0]     r_bufid,    w_bufid;
    logic [6:0]     r_offset,   w_offset;
    logic           r_pkt_rd,   w_pkt_rd;
    logic [15:0]    r_bufadd,   w_bufadd;
    logic [133:0]   r_pkt,      w_pkt;
    logic           r_pkt_wr,   w_pkt_wr;
    logic           r_rel,      w_rel;
    logic [8:0]     r_rel_id,   w_rel_id;
    logic           r_err,      w_err;
    logic           r_ready,    w_ready;

    // Word classification of the data returned with the ack.
    logic [1:0]     w_type;
    logic           w_is_last_type;   // 10 or 11: packet ends with this word
    logic           w_is_head_type;   // 01 or 11: valid first word
    logic           w_last_offset;    // last word slot of the buffer

    assign w_type         = bus.iv_pkt_rdata[133:132];
    assign w_is_last_type = w_type[1];
    assign w_is_head_type = w_type[0];
    assign w_last_offset  = (r_offset == 7'h7F);

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_bufid     = r_bufid;
        w_offset    = r_offset;
        w_pkt_rd    = r_pkt_rd;
        w_bufadd    = r_bufadd;
        w_pkt       = '0;        // packet word and strobes are single-cycle
        w_pkt_wr    = 1'b0;
        w_rel       = 1'b0;
        w_rel_id    = '0;
        w_err       = 1'b0;
        w_ready     = r_ready;

        case (r_state)
            IDLE_S: begin
                if (bus.i_pkt_bufid_wr && r_ready) begin
                    w_bufid     = bus.iv_pkt_bufid;
                    w_offset    = 7'd0;
                    w_ready     = 1'b0;
                    w_state_nxt = RD_REQ_S;
                end
            end

            RD_REQ_S: begin
                if (!bus.i_fifo_afull) begin
                    w_pkt_rd    = 1'b1;
                    w_bufadd    = {r_bufid, r_offset};
                    w_state_nxt = WAIT_ACK_S;
                end
            end

            WAIT_ACK_S: begin
                // The request stays up until it is acked. The almost-full flag
                // is only checked before a new request is issued.
                if (bus.i_pkt_ack && r_pkt_rd) begin
                    w_pkt_rd = 1'b0;
                    w_pkt    = bus.iv_pkt_rdata;
                    w_pkt_wr = 1'b1;
                    // Flag a bad first word, and flag a buffer that filled up
                    // without a tail. The word is forwarded in both cases.
                    w_err    = ((r_offset == 7'd0) && !w_is_head_type) ||
                               (w_last_offset && !w_is_last_type);
                    if (w_is_last_type || w_last_offset) begin
                        w_state_nxt = RELEASE_S;
                    end else begin
                        w_offset    = r_offset + 7'd1;
                        w_state_nxt = RD_REQ_S;
                    end
                end
            end

            RELEASE_S: begin
                // This state takes two cycles. First cycle: pulse the release.
                // Second cycle: reopen for a new bufid.
                if (!r_rel) begin
                    w_rel    = 1'b1;
                    w_rel_id = r_bufid;
                end else begin
                    w_bufadd    = '0;
                    w_ready     = 1'b1;
                    w_state_nxt = IDLE_S;
                end
            end

            default: begin
                w_state_nxt = IDLE_S;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE_S;
            r_bufid  <= '0;
            r_offset <= '0;
            r_pkt_rd <= 1'b0;
            r_bufadd <= '0;
            r_pkt    <= '0;
            r_pkt_wr <= 1'b0;
            r_rel    <= 1'b0;
            r_rel_id <= '0;
            r_err    <= 1'b0;
            r_ready  <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_bufid  <= w_bufid;
            r_offset <= w_offset;
            r_pkt_rd <= w_pkt_rd;
            r_bufadd <= w_bufadd;
            r_pkt    <= w_pkt;
            r_pkt_wr <= w_pkt_wr;
            r_rel    <= w_rel;
            r_rel_id <= w_rel_id;
            r_err    <= w_err;
            r_ready  <= w_ready;
        end
    end

    assign bus.o_bufid_ready           = r_ready;
    assign bus.o_pkt_rd                = r_pkt_rd;
    assign bus.ov_pkt_bufadd           = r_bufadd;
    assign bus.ov_pkt                  = r_pkt;
    assign bus.o_pkt_wr                = r_pkt_wr;
    assign bus.o_bufid_release         = r_rel;
    assign bus.ov_bufid_release        = r_rel_id;
    assign bus.o_pkt_err               = r_err;
    assign output_buf_interface_state  = r_state;

endmodule

// File: tb/tb_output_buffer_interface.sv
// -----------------------------------------------------------------------------
// tb_output_buffer_interface
//   Directed bench for output_buffer_interface.
//   - A PCB responder process answers each read request after ack_delay cycles.
//   - A packet model turns a list of word types into the expected addresses,
//     forwarded words, error flags and the release.
//   - One compare process checks the outputs against the model on every cycle.
// -----------------------------------------------------------------------------
module tb_output_buffer_interface;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;
    int         total;
    int         bad;
    int         cyc;

    output_buffer_interface_if bus_if();

    output_buffer_interface dut (
        .i_clk                      (clk),
        .i_rst_n                    (rst_n),
        .bus                        (bus_if),
        .output_buf_interface_state (dbg_state)
    );

    // ---------------- clock / reset / cycle count ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- model state ----------------
    logic [133:0] pcb_mem [logic [15:0]];
    logic [1:0]   types_q [$];
    logic [15:0]  exp_addr_q [$];
    logic [133:0] exp_q [$];
    logic [0:0]   exp_err_q [$];
    logic [0:0]   exp_last_q [$];
    logic [8:0]   exp_rel_q [$];
    int           ack_delay;
    int           wait_cnt;
    bit           sb_en;

    task automatic chk(input string nm, input logic [133:0] act, input logic [133:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: act=%h req=%h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Build the expected behaviour of one packet from its list of word types.
    // The packet ends at the first 10/11 word or at buffer slot 127.
    task automatic build_packet(input logic [8:0] id);
        logic [159:0] rnd;
        logic [133:0] w;
        logic [1:0]   t;
        logic [6:0]   off;
        bit           head_ok, ends, last;
        for (int i = 0; i < types_q.size() && i < 128; i++) begin
            t       = types_q[i];
            off     = i[6:0];
            rnd     = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            w       = {t, rnd[131:0]};
            pcb_mem[{id, off}] = w;
            head_ok = (t == 2'b01) || (t == 2'b11);
            ends    = (t == 2'b10) || (t == 2'b11);
            last    = ends || (i == 127);
            exp_addr_q.push_back({id, off});
            exp_q.push_back(w);
            exp_err_q.push_back(((i == 0) && !head_ok) || ((i == 127) && !ends));
            exp_last_q.push_back(last);
            if (last) break;
        end
        exp_rel_q.push_back(id);
    endtask

    task automatic clear_model();
        exp_addr_q.delete();
        exp_q.delete();
        exp_err_q.delete();
        exp_last_q.delete();
        exp_rel_q.delete();
        types_q.delete();
    endtask

    // ---------------- PCB responder ----------------
    initial begin
        bus_if.i_pkt_ack    = 1'b0;
        bus_if.iv_pkt_rdata = '0;
        wait_cnt            = 0;
        forever begin
            @(posedge clk); #1;
            bus_if.i_pkt_ack    = 1'b0;
            bus_if.iv_pkt_rdata = '0;
            if (!rst_n) begin
                wait_cnt = 0;
            end else if (bus_if.o_pkt_rd) begin
                if (wait_cnt >= ack_delay) begin
                    bus_if.i_pkt_ack    = 1'b1;
                    bus_if.iv_pkt_rdata = pcb_mem.exists(bus_if.ov_pkt_bufadd) ?
                                          pcb_mem[bus_if.ov_pkt_bufadd] : '0;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // ---------------- compare process ----------------
    logic        prev_rd;
    logic [15:0] prev_addr;
    int          rel_due;
    int          ready_due;

    always @(negedge clk) begin
        if (!rst_n || !sb_en) begin
            prev_rd   = 1'b0;
            rel_due   = -1;
            ready_due = -1;
        end else begin
            // read requests: the address matches the model, and it stays stable while held
            if (bus_if.o_pkt_rd && !prev_rd) begin
                if (exp_addr_q.size() == 0)
                    chk("unexpected_rd", {118'd0, bus_if.ov_pkt_bufadd}, 134'd0);
                else
                    chk("rd_addr", {118'd0, bus_if.ov_pkt_bufadd}, {118'd0, exp_addr_q.pop_front()});
            end else if (bus_if.o_pkt_rd && prev_rd) begin
                chk("rd_addr_hold", {118'd0, bus_if.ov_pkt_bufadd}, {118'd0, prev_addr});
            end
            prev_rd   = bus_if.o_pkt_rd;
            prev_addr = bus_if.ov_pkt_bufadd;

            // forwarded words
            if (bus_if.o_pkt_wr) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_wr", bus_if.ov_pkt, 134'd0);
                end else begin
                    chk("pkt_data", bus_if.ov_pkt, exp_q.pop_front());
                    chk("pkt_err", {133'd0, bus_if.o_pkt_err}, {133'd0, exp_err_q.pop_front()});
                    if (exp_last_q.pop_front()) rel_due = cyc + 1;
                end
            end else begin
                chk("pkt_idle", bus_if.ov_pkt, 134'd0);
                chk("err_idle", {133'd0, bus_if.o_pkt_err}, 134'd0);
            end

            // release: one cycle after the last word, ready one cycle after that
            if (cyc == rel_due)
                chk("rel_pulse", {133'd0, bus_if.o_bufid_release}, 134'd1);
            if (bus_if.o_bufid_release) begin
                if (exp_rel_q.size() == 0) begin
                    chk("unexpected_rel", {125'd0, bus_if.ov_bufid_release}, 134'd0);
                end else begin
                    chk("rel_id", {125'd0, bus_if.ov_bufid_release}, {125'd0, exp_rel_q.pop_front()});
                    chk("rel_time", cyc, rel_due);
                    chk("ready_at_rel", {133'd0, bus_if.o_bufid_ready}, 134'd0);
                    ready_due = cyc + 1;
                end
            end
            if (cyc == ready_due)
                chk("ready_after_rel", {133'd0, bus_if.o_bufid_ready}, 134'd1);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_bufid(input logic [8:0] id);
        bus_if.iv_pkt_bufid   = id;
        bus_if.i_pkt_bufid_wr = 1'b1;
        @(posedge clk); #1;
        bus_if.i_pkt_bufid_wr = 1'b0;
    endtask

    task automatic wait_rd(input string nm);
        bit seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #2;
            if (bus_if.o_pkt_rd) begin seen = 1; break; end
        end
        chk(nm, {133'd0, seen}, 134'd1);
    endtask

    task automatic wait_wr(input string nm);
        bit seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #2;
            if (bus_if.o_pkt_wr) begin seen = 1; break; end
        end
        chk(nm, {133'd0, seen}, 134'd1);
    endtask

    task automatic wait_done(input string nm);
        bit seen = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            if (bus_if.o_bufid_ready && exp_rel_q.size() == 0) begin seen = 1; break; end
        end
        chk({nm, "_done"}, {133'd0, seen}, 134'd1);
        chk({nm, "_words_left"}, exp_q.size(), 134'd0);
        chk({nm, "_addr_left"}, exp_addr_q.size(), 134'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        total = 0; bad = 0; cyc = 0; sb_en = 1'b1; ack_delay = 0;
        rst_n = 1'b0;
        bus_if.i_pkt_bufid_wr = 1'b0;
        bus_if.iv_pkt_bufid   = '0;
        bus_if.i_fifo_afull   = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        // reset state
        chk("rst_ready", {133'd0, bus_if.o_bufid_ready}, 134'd1);
        chk("rst_state", {132'd0, dbg_state}, 134'd0);
        chk("rst_rd",    {133'd0, bus_if.o_pkt_rd}, 134'd0);
        chk("rst_addr",  {118'd0, bus_if.ov_pkt_bufadd}, 134'd0);
        chk("rst_pkt",   bus_if.ov_pkt, 134'd0);
        chk("rst_rel",   {125'd0, bus_if.o_bufid_release, bus_if.ov_bufid_release}, 134'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single-word packet, bufid 0x005
        ack_delay = 0;
        types_q = '{2'b11};
        build_packet(9'h005);
        chk("model_sw_addr", {118'd0, exp_addr_q[0]}, 134'h0280);
        send_bufid(9'h005);
        chk("sw_no_rd_yet", {133'd0, bus_if.o_pkt_rd}, 134'd0);
        @(posedge clk); #2;
        chk("sw_rd_latency", {133'd0, bus_if.o_pkt_rd}, 134'd1);
        chk("sw_addr_lit", {118'd0, bus_if.ov_pkt_bufadd}, 134'h0280);
        wait_done("single");
        clear_model();
        @(posedge clk); #1;

        // 4-word packet, bufid 0x1FF, ack two cycles after each request
        ack_delay = 2;
        types_q = '{2'b01, 2'b00, 2'b00, 2'b10};
        build_packet(9'h1FF);
        chk("model_4w_first", {118'd0, exp_addr_q[0]}, 134'hFF80);
        chk("model_4w_last",  {118'd0, exp_addr_q[3]}, 134'hFF83);
        send_bufid(9'h1FF);
        wait_done("four");
        clear_model();
        @(posedge clk); #1;

        // bad first word: a body word at offset 0 still goes out, flagged
        ack_delay = 0;
        types_q = '{2'b00, 2'b10};
        build_packet(9'h042);
        chk("model_headerr", {133'd0, exp_err_q[0]}, 134'd1);
        send_bufid(9'h042);
        wait_done("headerr");
        clear_model();
        @(posedge clk); #1;

        // backpressure after word 0 is accepted
        ack_delay = 3;
        types_q = '{2'b01, 2'b00, 2'b10};
        build_packet(9'h0A3);
        send_bufid(9'h0A3);
        wait_rd("bp_first_rd");
        bus_if.i_fifo_afull = 1'b1;
        wait_wr("bp_first_wr");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #2;
            chk("bp_no_rd", {133'd0, bus_if.o_pkt_rd}, 134'd0);
        end
        bus_if.i_fifo_afull = 1'b0;
        @(posedge clk); #2;
        chk("bp_resume_rd", {133'd0, bus_if.o_pkt_rd}, 134'd1);
        chk("bp_resume_addr", {118'd0, bus_if.ov_pkt_bufadd}, 134'h5181);
        wait_done("bp");
        clear_model();
        @(posedge clk); #1;

        // ack held off for 20 cycles
        ack_delay = 20;
        types_q = '{2'b11};
        build_packet(9'h011);
        send_bufid(9'h011);
        wait_rd("aw_rd");
        for (int i = 0; i < 18; i++) begin
            @(posedge clk); #2;
            chk("aw_rd_held", {133'd0, bus_if.o_pkt_rd}, 134'd1);
            chk("aw_addr_held", {118'd0, bus_if.ov_pkt_bufadd}, 134'h0880);
            chk("aw_no_wr", {133'd0, bus_if.o_pkt_wr}, 134'd0);
        end
        wait_done("ackwait");
        clear_model();
        @(posedge clk); #1;

        // overflow: head followed by 127 body words and no tail
        ack_delay = 0;
        types_q.push_back(2'b01);
        repeat (127) types_q.push_back(2'b00);
        build_packet(9'h100);
        chk("model_ovf_len", exp_q.size(), 134'd128);
        chk("model_ovf_addr", {118'd0, exp_addr_q[127]}, 134'h807F);
        chk("model_ovf_err", {132'd0, exp_err_q[126], exp_err_q[127]}, 134'b01);
        send_bufid(9'h100);
        wait_done("overflow");
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #2;
            chk("ovf_no_more_rd", {133'd0, bus_if.o_pkt_rd}, 134'd0);
        end
        clear_model();
        @(posedge clk); #1;

        // reset while waiting for an ack
        ack_delay = 50;
        types_q = '{2'b01, 2'b10};
        build_packet(9'h033);
        send_bufid(9'h033);
        wait_rd("mr_rd");
        repeat (3) @(posedge clk);
        #3;
        chk("mr_state_before", {132'd0, dbg_state}, 134'd2);
        sb_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mr_ready", {133'd0, bus_if.o_bufid_ready}, 134'd1);
        chk("mr_state", {132'd0, dbg_state}, 134'd0);
        chk("mr_rd",    {133'd0, bus_if.o_pkt_rd}, 134'd0);
        chk("mr_addr",  {118'd0, bus_if.ov_pkt_bufadd}, 134'd0);
        chk("mr_outs",  {bus_if.o_pkt_wr, bus_if.o_pkt_err, bus_if.o_bufid_release,
                         bus_if.ov_bufid_release, bus_if.ov_pkt[121:0]}, 134'd0);
        clear_model();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        sb_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #2;
            chk("mr_no_release", {133'd0, bus_if.o_bufid_release}, 134'd0);
            chk("mr_idle", {132'd0, dbg_state}, 134'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
